fpu_fp64_rcp_seq: RTL and testbench
===================================

Name: fpu_fp64_rcp_seq

Overview:
Sequencer that turns the FP64 table-based approximate reciprocal unit into a usable FP64 reciprocal/divide operation. It takes one request, drives the reciprocal approximation unit, then runs NR_ITER Newton-Raphson refinements x' = x*(2 - d*x). The refinements use a multiplier and an adder shared with the rest of the FPU, each through a valid/done handshake. For divide, it finishes with q = a*x. Sits between the FPU issue logic and the rcp/mul/add datapath units.

Parameters:
NR_ITER, 2, number of Newton-Raphson refinement passes (0..3); 0 returns the raw approximation.
RCP_LAT, 1, cycles from rcpSrc stable to rcpDst valid.

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
reqValid  in  1  request present
reqReady  out  1  block idle, request accepted when reqValid&reqReady
reqOp  in  1  0=reciprocal of reqB, 1=divide reqA/reqB
reqA  in  64  FP64 numerator (ignored when reqOp=0)
reqB  in  64  FP64 divisor/operand
respValid  out  1  result valid, held until respReady
respReady  in  1  consumer accepts result
respData  out  64  FP64 result
rcpSrc  out  64  operand to reciprocal approximation unit
rcpDst  in  64  approximation result
mulValid  out  1  multiply request, held until mulDone
mulA, mulB  out  64  multiplier operands, stable while mulValid
mulDone  in  1  one-cycle pulse, mulRes valid
mulRes  in  64  product
addValid  out  1  add request, held until addDone
addA, addB  out  64  adder operands, stable while addValid
addDone  in  1  one-cycle pulse, addRes valid
addRes  in  64  sum

Behaviour:
- Reset: state IDLE; reqReady=1; respValid=0; mulValid=0; addValid=0; respData=0; rcpSrc=0; iteration counter=0.
- reqReady=1 only in IDLE. On accept, latch reqOp/reqA/reqB and drive rcpSrc=reqB.
- States: IDLE, CLASS, RCP, MUL_DX, SUB, MUL_XU, MUL_AQ, DONE.
- CLASS (1 cycle) classifies reqB by exponent/fraction:
  - zero -> x = signed Inf.
  - Inf -> x = signed zero.
  - NaN -> x = 0x7FF8000000000000.
  - For these three, go to MUL_AQ if divide, else DONE. Otherwise go to RCP.
- RCP: wait RCP_LAT cycles, latch x=rcpDst. If NR_ITER=0, go to MUL_AQ/DONE; otherwise go to MUL_DX.
- MUL_DX: mulA=d, mulB=x. On mulDone latch t=mulRes, go to SUB.
- SUB: addA=0x4000000000000000 (2.0), addB=t with bit63 inverted. On addDone latch u=addRes, go to MUL_XU.
- MUL_XU: mulA=x, mulB=u. On mulDone x=mulRes and counter++. If counter==NR_ITER, go to MUL_AQ (divide) or DONE (reciprocal); otherwise go to MUL_DX.
- MUL_AQ: mulA=a, mulB=x. On mulDone latch q.
- DONE: respValid=1, respData = x or q. Hold stable while respReady=0. On respValid&respReady, clear respValid and return to IDLE with counter=0. No new request is accepted in the same cycle.
- mulValid/addValid rise in the cycle after state entry and drop in the cycle after the done pulse. Never both high together.
- Done pulses arriving while the matching valid is low are ignored.
- Reset mid-operation: return to reset state the next cycle regardless of outstanding handshakes. Late done pulses after reset are ignored.
- No rounding or normalisation is done here; the block only forwards datapath results. Sign of result = sign(a) xor sign(b) is produced by the datapath.

Decomposition:
- Shared package: FP64 constants (FP64_TWO, FP64_QNAN, FP64_INF_POS, exponent all-ones mask), state enum, and classify function (zero/inf/nan/normal).
- One natural sub-module: fpu_fp64_class, combinational FP64 operand classifier, reused by other FPU sequencers.

Test Plan:
- Bench uses single-cycle mul/add models and the real rcp unit.
- reqOp=0, reqB=0x4000000000000000 (2.0), NR_ITER=2 -> respData=0x3FE0000000000000 (0.5). Exactly 2 mul-add-mul passes observed.
- reqOp=1, reqA=0x4018000000000000 (6.0), reqB=0x4008000000000000 (3.0) -> respData within 1 ulp of 0x4000000000000000; 5 mulValid handshakes, 2 addValid handshakes.
- reqOp=0, reqB=0x0000000000000000 -> respData=0x7FF0000000000000, no mul/add activity. reqB=0xFFF0000000000000 -> respData=0x8000000000000000.
- reqOp=1, reqB=NaN 0x7FF0000000000001 -> exactly one multiply issued with mulB=0x7FF8000000000000.
- Hold respReady=0 for 10 cycles after respValid -> respData stable, reqReady=0. Raise respReady -> respValid drops next cycle, reqReady=1.
- Assert reset while mulValid=1 in MUL_XU, then pulse mulDone after reset -> all outputs at reset values, no respValid. The next request completes correctly.

Source files
------------

// File: rtl/fpu_fp64_rcp_seq_pkg.sv
// Shared FP64 constants, sequencer state encodings and operand classification
// for the reciprocal/divide sequencer.
package fpu_fp64_rcp_seq_pkg;

  localparam logic [63:0] FP64_TWO      = 64'h4000_0000_0000_0000;
  localparam logic [63:0] FP64_QNAN     = 64'h7FF8_0000_0000_0000;
  localparam logic [63:0] FP64_INF_POS  = 64'h7FF0_0000_0000_0000;
  localparam logic [63:0] FP64_EXP_MASK = 64'h7FF0_0000_0000_0000;

  typedef logic [2:0] state_t;

  localparam state_t StIdle  = 3'd0;
  localparam state_t StClass = 3'd1;
  localparam state_t StRcp   = 3'd2;
  localparam state_t StMulDx = 3'd3;
  localparam state_t StSub   = 3'd4;
  localparam state_t StMulXu = 3'd5;
  localparam state_t StMulAq = 3'd6;
  localparam state_t StDone  = 3'd7;

  typedef enum logic [1:0] {
    FpNormal = 2'd0,
    FpZero   = 2'd1,
    FpInf    = 2'd2,
    FpNan    = 2'd3
  } fp_class_e;

  // Subnormals count as normal: the approximation unit handles them.
  function automatic fp_class_e fp64_classify(input logic [63:0] v);
    fp_class_e res;
    logic      exp_ones;
    logic      exp_zero;
    logic      frac_zero;
    exp_ones  = (v & FP64_EXP_MASK) == FP64_EXP_MASK;
    exp_zero  = (v & FP64_EXP_MASK) == 64'd0;
    frac_zero = v[51:0] == 52'd0;
    if (exp_ones) begin
      res = frac_zero ? FpInf : FpNan;
    end else if (exp_zero && frac_zero) begin
      res = FpZero;
    end else begin
      res = FpNormal;
    end
    return res;
  endfunction

endpackage

// File: rtl/fpu_fp64_class.sv
// Combinational FP64 operand classifier (zero / inf / nan / normal).
module fpu_fp64_class
  import fpu_fp64_rcp_seq_pkg::*;
(
  input  logic [63:0] op_i,
  output fp_class_e   class_o
);

  assign class_o = fp64_classify(op_i);

endmodule

// File: rtl/fpu_fp64_rcp_seq.sv
// FP64 reciprocal/divide sequencer: table approximation, Newton-Raphson
// refinement on the shared multiplier/adder, optional final a*x.
module fpu_fp64_rcp_seq
  import fpu_fp64_rcp_seq_pkg::*;
#(
  parameter int unsigned NR_ITER = 2,
  parameter int unsigned RCP_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic        reqOp,
  input  logic [63:0] reqA,
  input  logic [63:0] reqB,
  output logic        respValid,
  input  logic        respReady,
  output logic [63:0] respData,
  output logic [63:0] rcpSrc,
  input  logic [63:0] rcpDst,
  output logic        mulValid,
  output logic [63:0] mulA,
  output logic [63:0] mulB,
  input  logic        mulDone,
  input  logic [63:0] mulRes,
  output logic        addValid,
  output logic [63:0] addA,
  output logic [63:0] addB,
  input  logic        addDone,
  input  logic [63:0] addRes
);

  localparam logic [1:0] NrIterL = 2'(NR_ITER);
  localparam logic [3:0] RcpLatL = 4'(RCP_LAT);

  state_t      state_q, state_d;
  logic        op_q, op_d;
  logic [63:0] a_q, a_d;
  logic [63:0] b_q, b_d;
  logic [63:0] x_q, x_d;
  logic [63:0] t_q, t_d;
  logic [63:0] u_q, u_d;
  logic [63:0] q_q, q_d;
  logic [63:0] rcp_src_q, rcp_src_d;
  logic [1:0]  iter_q, iter_d;
  logic [3:0]  wait_q, wait_d;
  logic        mul_valid_q, mul_valid_d;
  logic        add_valid_q, add_valid_d;

  fp_class_e   b_class;
  state_t      fin_state;
  logic        in_mul_state;
  logic        mul_hs;
  logic        add_hs;

  fpu_fp64_class u_class (
    .op_i    (b_q),
    .class_o (b_class)
  );

  assign fin_state    = op_q ? StMulAq : StDone;
  assign in_mul_state = (state_q == StMulDx) || (state_q == StMulXu) || (state_q == StMulAq);
  // Done pulses only count while the matching request is outstanding.
  assign mul_hs       = mul_valid_q && mulDone;
  assign add_hs       = add_valid_q && addDone;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    x_d         = x_q;
    t_d         = t_q;
    u_d         = u_q;
    q_d         = q_q;
    rcp_src_d   = rcp_src_q;
    iter_d      = iter_q;
    wait_d      = wait_q;
    mul_valid_d = mul_valid_q;
    add_valid_d = add_valid_q;

    // Valids rise the cycle after state entry and drop the cycle after done.
    if (mul_hs) begin
      mul_valid_d = 1'b0;
    end else if (in_mul_state && !mul_valid_q) begin
      mul_valid_d = 1'b1;
    end
    if (add_hs) begin
      add_valid_d = 1'b0;
    end else if ((state_q == StSub) && !add_valid_q) begin
      add_valid_d = 1'b1;
    end

    case (state_q)
      StIdle: begin
        if (reqValid) begin
          op_d      = reqOp;
          a_d       = reqA;
          b_d       = reqB;
          rcp_src_d = reqB;
          state_d   = StClass;
        end
      end
      StClass: begin
        unique case (b_class)
          FpZero: begin
            x_d     = FP64_INF_POS | {b_q[63], 63'd0};
            state_d = fin_state;
          end
          FpInf: begin
            x_d     = {b_q[63], 63'd0};
            state_d = fin_state;
          end
          FpNan: begin
            x_d     = FP64_QNAN;
            state_d = fin_state;
          end
          FpNormal: begin
            wait_d  = 4'd0;
            state_d = StRcp;
          end
        endcase
      end
      StRcp: begin
        if (wait_q + 4'd1 >= RcpLatL) begin
          x_d     = rcpDst;
          state_d = (NR_ITER == 0) ? fin_state : StMulDx;
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end
      StMulDx: begin
        if (mul_hs) begin
          t_d     = mulRes;
          state_d = StSub;
        end
      end
      StSub: begin
        if (add_hs) begin
          u_d     = addRes;
          state_d = StMulXu;
        end
      end
      StMulXu: begin
        if (mul_hs) begin
          x_d     = mulRes;
          iter_d  = iter_q + 2'd1;
          state_d = (iter_q + 2'd1 == NrIterL) ? fin_state : StMulDx;
        end
      end
      StMulAq: begin
        if (mul_hs) begin
          q_d     = mulRes;
          state_d = StDone;
        end
      end
      StDone: begin
        if (respReady) begin
          iter_d  = 2'd0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      op_q        <= 1'b0;
      a_q         <= 64'd0;
      b_q         <= 64'd0;
      x_q         <= 64'd0;
      t_q         <= 64'd0;
      u_q         <= 64'd0;
      q_q         <= 64'd0;
      rcp_src_q   <= 64'd0;
      iter_q      <= 2'd0;
      wait_q      <= 4'd0;
      mul_valid_q <= 1'b0;
      add_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      x_q         <= x_d;
      t_q         <= t_d;
      u_q         <= u_d;
      q_q         <= q_d;
      rcp_src_q   <= rcp_src_d;
      iter_q      <= iter_d;
      wait_q      <= wait_d;
      mul_valid_q <= mul_valid_d;
      add_valid_q <= add_valid_d;
    end
  end

  always_comb begin
    mulA = 64'd0;
    mulB = 64'd0;
    case (state_q)
      StMulDx: begin
        mulA = b_q;
        mulB = x_q;
      end
      StMulXu: begin
        mulA = x_q;
        mulB = u_q;
      end
      StMulAq: begin
        mulA = a_q;
        mulB = x_q;
      end
      default: ;
    endcase
  end

  // addB = -t, so the adder computes 2 - d*x.
  assign addA      = (state_q == StSub) ? FP64_TWO : 64'd0;
  assign addB      = (state_q == StSub) ? {~t_q[63], t_q[62:0]} : 64'd0;

  assign reqReady  = (state_q == StIdle);
  assign respValid = (state_q == StDone);
  assign respData  = (state_q == StDone) ? (op_q ? q_q : x_q) : 64'd0;
  assign rcpSrc    = rcp_src_q;
  assign mulValid  = mul_valid_q;
  assign addValid  = add_valid_q;

endmodule

// File: tb/tb_fpu_fp64_rcp_seq.sv
// Scoreboard bench for fpu_fp64_rcp_seq with single-cycle mul/add models and a
// truncated-reciprocal approximation model.
module tb_fpu_fp64_rcp_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        reqValid, reqReady, reqOp;
  logic [63:0] reqA, reqB;
  logic        respValid, respReady;
  logic [63:0] respData;
  logic [63:0] rcpSrc;
  logic [63:0] rcpDst = 64'd0;
  logic        mulValid;
  logic [63:0] mulA, mulB;
  logic        mulDone = 1'b0;
  logic [63:0] mulRes = 64'd0;
  logic        addValid;
  logic [63:0] addA, addB;
  logic        addDone = 1'b0;
  logic [63:0] addRes = 64'd0;

  logic        mul_hold, mul_kick;
  int          n_tests = 0;
  int          n_fail = 0;
  int          mul_cnt = 0;
  int          add_cnt = 0;
  int          overlap = 0;
  int          resp_cnt = 0;
  logic [63:0] last_mulb = 64'd0;

  typedef struct {
    logic [63:0] data;
    bit          tol;
  } sb_entry_t;
  sb_entry_t sb_q[$];

  always #5 clk = ~clk;

  fpu_fp64_rcp_seq #(
    .NR_ITER (2),
    .RCP_LAT (1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .reqValid  (reqValid),
    .reqReady  (reqReady),
    .reqOp     (reqOp),
    .reqA      (reqA),
    .reqB      (reqB),
    .respValid (respValid),
    .respReady (respReady),
    .respData  (respData),
    .rcpSrc    (rcpSrc),
    .rcpDst    (rcpDst),
    .mulValid  (mulValid),
    .mulA      (mulA),
    .mulB      (mulB),
    .mulDone   (mulDone),
    .mulRes    (mulRes),
    .addValid  (addValid),
    .addA      (addA),
    .addB      (addB),
    .addDone   (addDone),
    .addRes    (addRes)
  );

  function automatic logic [63:0] fmul(input logic [63:0] a, input logic [63:0] b);
    return $realtobits($bitstoreal(a) * $bitstoreal(b));
  endfunction

  function automatic logic [63:0] fadd(input logic [63:0] a, input logic [63:0] b);
    return $realtobits($bitstoreal(a) + $bitstoreal(b));
  endfunction

  // Approximation keeps ~30 mantissa bits, like a table plus interpolation.
  function automatic logic [63:0] rcp_approx(input logic [63:0] s);
    logic [63:0] r;
    r = $realtobits(1.0 / $bitstoreal(s));
    return r & ~64'h3F_FFFF;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) begin
    rcpDst  <= rcp_approx(rcpSrc);
    mulDone <= (mulValid && !mulDone && !mul_hold) || mul_kick;
    mulRes  <= fmul(mulA, mulB);
    addDone <= addValid && !addDone;
    addRes  <= fadd(addA, addB);
    if (!reset) begin
      if (mulValid && mulDone) begin
        mul_cnt   <= mul_cnt + 1;
        last_mulb <= mulB;
      end
      if (addValid && addDone) add_cnt <= add_cnt + 1;
      if (mulValid && addValid) overlap <= overlap + 1;
    end
  end

  always @(negedge clk) begin
    if (!reset && respValid && respReady) begin
      if (sb_q.size() == 0) begin
        check_eq("sb_nonempty", 64'(sb_q.size()), 64'd1);
      end else begin
        sb_entry_t   e;
        logic [63:0] diff;
        e = sb_q.pop_front();
        if (e.tol) begin
          diff = (respData > e.data) ? respData - e.data : e.data - respData;
          check_eq("resp_ulp", {63'd0, diff <= 64'd1}, 64'd1);
        end else begin
          check_eq("resp_data", respData, e.data);
        end
      end
      resp_cnt <= resp_cnt + 1;
    end
  end

  task automatic do_req(input logic op, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp, input bit tol);
    int t;
    @(negedge clk);
    t = 0;
    while (!reqReady && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!reqReady) check_eq("req_ready_timeout", {63'd0, reqReady}, 64'd1);
    sb_q.push_back('{data: exp, tol: tol});
    reqValid = 1'b1;
    reqOp    = op;
    reqA     = a;
    reqB     = b;
    @(negedge clk);
    reqValid = 1'b0;
  endtask

  task automatic run(input logic op, input logic [63:0] a, input logic [63:0] b,
                     input logic [63:0] exp, input bit tol);
    int start;
    int t;
    start = resp_cnt;
    do_req(op, a, b, exp, tol);
    t = 0;
    while (resp_cnt == start && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (resp_cnt == start) check_eq("resp_timeout", 64'(resp_cnt - start), 64'd1);
    @(negedge clk);
  endtask

  task automatic check_idle();
    check_eq("idle_req_ready", {63'd0, reqReady}, 64'd1);
    check_eq("idle_resp_valid", {63'd0, respValid}, 64'd0);
    check_eq("idle_mul_valid", {63'd0, mulValid}, 64'd0);
    check_eq("idle_add_valid", {63'd0, addValid}, 64'd0);
    check_eq("idle_resp_data", respData, 64'd0);
    check_eq("idle_rcp_src", rcpSrc, 64'd0);
  endtask

  initial begin
    int m0, a0, t;
    bit stable;
    logic [63:0] d0;
    reset     = 1'b1;
    reqValid  = 1'b0;
    reqOp     = 1'b0;
    reqA      = 64'd0;
    reqB      = 64'd0;
    respReady = 1'b1;
    mul_hold  = 1'b0;
    mul_kick  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle();
    @(negedge clk);
    reset = 1'b0;

    // 1/2.0: exact approximation, two refinement passes.
    m0 = mul_cnt; a0 = add_cnt;
    run(1'b0, 64'd0, 64'h4000_0000_0000_0000, 64'h3FE0_0000_0000_0000, 1'b0);
    check_eq("rcp2_mul_cnt", 64'(mul_cnt - m0), 64'd4);
    check_eq("rcp2_add_cnt", 64'(add_cnt - a0), 64'd2);

    // 6.0 / 3.0.
    m0 = mul_cnt; a0 = add_cnt;
    run(1'b1, 64'h4018_0000_0000_0000, 64'h4008_0000_0000_0000,
        64'h4000_0000_0000_0000, 1'b1);
    check_eq("div_mul_cnt", 64'(mul_cnt - m0), 64'd5);
    check_eq("div_add_cnt", 64'(add_cnt - a0), 64'd2);

    // Special operands bypass the datapath for reciprocal.
    m0 = mul_cnt; a0 = add_cnt;
    run(1'b0, 64'd0, 64'h0000_0000_0000_0000, 64'h7FF0_0000_0000_0000, 1'b0);
    run(1'b0, 64'd0, 64'h8000_0000_0000_0000, 64'hFFF0_0000_0000_0000, 1'b0);
    run(1'b0, 64'd0, 64'hFFF0_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0);
    run(1'b0, 64'd0, 64'h7FF0_0000_0000_0001, 64'h7FF8_0000_0000_0000, 1'b0);
    check_eq("special_mul_cnt", 64'(mul_cnt - m0), 64'd0);
    check_eq("special_add_cnt", 64'(add_cnt - a0), 64'd0);

    // Divide by NaN: a single a*x multiply with x = QNaN.
    m0 = mul_cnt; a0 = add_cnt;
    run(1'b1, 64'h3FF0_0000_0000_0000, 64'h7FF0_0000_0000_0001,
        fmul(64'h3FF0_0000_0000_0000, 64'h7FF8_0000_0000_0000), 1'b0);
    check_eq("nan_mul_cnt", 64'(mul_cnt - m0), 64'd1);
    check_eq("nan_add_cnt", 64'(add_cnt - a0), 64'd0);
    check_eq("nan_mulb", last_mulb, 64'h7FF8_0000_0000_0000);

    // Backpressure: response held stable for 10 cycles.
    respReady = 1'b0;
    do_req(1'b0, 64'd0, 64'h4000_0000_0000_0000, 64'h3FE0_0000_0000_0000, 1'b0);
    t = 0;
    while (!respValid && t < 500) begin
      @(negedge clk);
      t++;
    end
    check_eq("hold_resp_valid", {63'd0, respValid}, 64'd1);
    d0 = respData;
    stable = 1'b1;
    repeat (10) begin
      @(negedge clk);
      stable &= (respData === d0) && (reqReady === 1'b0) && (respValid === 1'b1);
    end
    check_eq("hold_stable", {63'd0, stable}, 64'd1);
    @(posedge clk);
    #1 respReady = 1'b1;
    @(posedge clk);
    #1;
    check_eq("release_resp_valid", {63'd0, respValid}, 64'd0);
    check_eq("release_req_ready", {63'd0, reqReady}, 64'd1);

    // Reset while the x*u multiply is outstanding, then a stray mulDone.
    m0 = mul_cnt; a0 = add_cnt;
    do_req(1'b0, 64'd0, 64'h4008_0000_0000_0000, 64'd0, 1'b0);
    t = 0;
    while (add_cnt == a0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    mul_hold = 1'b1;
    t = 0;
    while (!mulValid && t < 50) begin
      @(negedge clk);
      t++;
    end
    check_eq("abort_mul_valid", {63'd0, mulValid}, 64'd1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    sb_q.delete();
    mul_hold = 1'b0;
    mul_kick = 1'b1;
    @(negedge clk);
    mul_kick = 1'b0;
    @(negedge clk);
    check_idle();
    repeat (5) @(negedge clk);
    check_eq("abort_no_resp", {63'd0, respValid}, 64'd0);
    check_eq("abort_mul_cnt", 64'(mul_cnt - m0), 64'd1);

    // Next request must see a cleared iteration counter.
    m0 = mul_cnt; a0 = add_cnt;
    run(1'b0, 64'd0, 64'h4000_0000_0000_0000, 64'h3FE0_0000_0000_0000, 1'b0);
    check_eq("post_mul_cnt", 64'(mul_cnt - m0), 64'd4);
    check_eq("post_add_cnt", 64'(add_cnt - a0), 64'd2);
    check_eq("mul_add_overlap", 64'(overlap), 64'd0);
    check_eq("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
